// File: rtl/bsnn_spike_classifier.sv
// bsnn_spike_classifier: per-class spike counts over a frame of spike vectors, then a sequential argmax scan.
module bsnn_spike_classifier #(
  parameter int N_NEURONS   = 256,
  parameter int NUM_CLASSES = 8,
  parameter int TIMESTEPS   = 16,
  localparam int GROUP = N_NEURONS / NUM_CLASSES,
  localparam int CNT_W = $clog2(GROUP * TIMESTEPS + 1),
  localparam int IDX_W = $clog2(NUM_CLASSES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [N_NEURONS-1:0] spikes_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [IDX_W-1:0]     class_out,
  output logic [CNT_W-1:0]     score_out
);
  localparam int STEP_W = TIMESTEPS > 1 ? $clog2(TIMESTEPS) : 1;

  if (N_NEURONS % NUM_CLASSES != 0 || NUM_CLASSES < 2 || TIMESTEPS < 1) begin : g_bad_params
    $error("bsnn_spike_classifier: illegal parameter combination");
  end

  typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step;
  logic [IDX_W-1:0]  idx, best_idx;
  logic [CNT_W-1:0]  best_score;
  logic [CNT_W-1:0]  acc [NUM_CLASSES];
  logic [CNT_W-1:0]  pop [NUM_CLASSES];
  logic              accept, last_step, last_idx, better;

  assign ready_in  = state == ACCUM;
  assign valid_out = state == OUT;
  assign accept    = valid_in && ready_in;
  assign last_step = step == STEP_W'(TIMESTEPS - 1);
  assign last_idx  = idx == IDX_W'(NUM_CLASSES - 1);
  assign better    = acc[idx] > best_score;

  always_comb
    for (int c = 0; c < NUM_CLASSES; c++)
      pop[c] = CNT_W'($countones(spikes_in[c*GROUP +: GROUP]));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCUM;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    state_nxt = (accept && last_step)        ? SCAN  :
                (state == SCAN && last_idx)  ? OUT   :
                (valid_out && ready_out)     ? ACCUM : state;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step       <= '0;
      idx        <= '0;
      best_idx   <= '0;
      best_score <= '0;
      class_out  <= '0;
      score_out  <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
    end else begin
      if (accept) begin
        for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= acc[c] + pop[c];
        step <= last_step ? '0 : step + STEP_W'(1);
        if (last_step) begin
          idx        <= '0;
          best_idx   <= '0;
          best_score <= '0;
        end
      end
      if (state == SCAN) begin
        if (better) begin
          best_score <= acc[idx];
          best_idx   <= idx;
        end
        idx <= idx + IDX_W'(1);
        // Outputs are loaded only at the end of the scan so they hold across the next frame.
        if (last_idx) begin
          class_out <= better ? idx : best_idx;
          score_out <= better ? acc[idx] : best_score;
        end
      end
      if (valid_out && ready_out)
        for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
    end
endmodule

// File: tb/tb_bsnn_spike_classifier.sv
// tb_bsnn_spike_classifier: directed frame vectors plus backpressure, gap and mid-frame reset sequences.
module tb_bsnn_spike_classifier;
  logic         clk = 0, rst = 1, valid_in = 0, ready_out = 1;
  logic [255:0] spikes_in = '0;
  logic         ready_in, valid_out;
  logic [2:0]   class_out;
  logic [9:0]   score_out;
  int           errors = 0, checks = 0;

  typedef struct {
    logic [255:0] spikes;
    int           cls;
    int           score;
  } vec_t;
  vec_t tbl [5];

  bsnn_spike_classifier dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .spikes_in(spikes_in),
    .valid_out(valid_out), .ready_out(ready_out), .class_out(class_out), .score_out(score_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [255:0] grp(input int c, input int n);
    logic [255:0] r = '0;
    for (int i = 0; i < n; i++) r[c*32 + i] = 1'b1;
    return r;
  endfunction

  task automatic beat(input logic [255:0] v, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    valid_in  = 1;
    spikes_in = v;
    @(posedge clk);
    #1;
    valid_in  = 0;
    spikes_in = '0;
  endtask

  task automatic frame(input logic [255:0] v, input int maxgap);
    for (int i = 0; i < 16; i++) beat(v, int'($urandom_range(maxgap, 0)));
  endtask

  task automatic result(input string name, input int cls, input int score);
    int lat = 0;
    while (!valid_out && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, 8);
    check({name, " class"}, int'(class_out), cls);
    check({name, " score"}, int'(score_out), score);
  endtask

  task automatic handshake(input string name, input int cls, input int score);
    @(posedge clk);
    #1;
    check({name, " valid_out drop"}, int'(valid_out), 0);
    check({name, " ready_in back"}, int'(ready_in), 1);
    check({name, " class held"}, int'(class_out), cls);
    check({name, " score held"}, int'(score_out), score);
  endtask

  initial begin
    int bad;
    tbl[0] = '{grp(3, 32), 3, 512};
    tbl[1] = '{grp(2, 4) | grp(5, 4) | grp(0, 1), 2, 64};
    tbl[2] = '{{256{1'b1}}, 0, 512};
    tbl[3] = '{grp(1, 3) | grp(6, 5), 6, 80};
    tbl[4] = '{grp(0, 1) | grp(7, 2), 7, 32};

    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("reset valid_out", int'(valid_out), 0);
    check("reset ready_in", int'(ready_in), 1);
    check("reset class", int'(class_out), 0);
    check("reset score", int'(score_out), 0);

    for (int i = 0; i < 5; i++) begin
      frame(tbl[i].spikes, 0);
      result($sformatf("vec%0d", i), tbl[i].cls, tbl[i].score);
      handshake($sformatf("vec%0d", i), tbl[i].cls, tbl[i].score);
    end

    frame('0, 3);
    result("zero gaps", 0, 0);
    handshake("zero gaps", 0, 0);

    ready_out = 0;
    frame(grp(3, 32), 0);
    result("bp", 3, 512);
    bad = 0;
    repeat (20) begin
      valid_in  = 1;
      spikes_in = '1;
      @(posedge clk);
      #1;
      if (!valid_out || class_out != 3'd3 || score_out != 10'd512 || ready_in) bad++;
    end
    valid_in  = 0;
    spikes_in = '0;
    check("bp stable cycles bad", bad, 0);
    ready_out = 1;
    handshake("bp", 3, 512);
    frame(grp(7, 32), 0);
    result("bp next", 7, 512);
    handshake("bp next", 7, 512);

    for (int i = 0; i < 7; i++) beat(grp(1, 32), 0);
    #2;
    rst = 1;
    #1;
    check("midrst valid_out", int'(valid_out), 0);
    check("midrst class", int'(class_out), 0);
    check("midrst score", int'(score_out), 0);
    @(posedge clk);
    #1;
    rst = 0;
    frame(grp(4, 2), 0);
    result("midrst", 4, 32);
    handshake("midrst", 4, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bsnn_spike_classifier.md
Name: bsnn_spike_classifier

Overview:
Downstream consumer of the BSNN stream wrapper's spike-vector output. It accepts TIMESTEPS consecutive N_NEURONS-bit spike vectors per frame over a valid/ready stream. The neurons are split into NUM_CLASSES equal contiguous groups, and the block accumulates a per-group spike count across the frame. It then runs a sequential argmax scan and emits the winning class index and its score over a valid/ready output stream.

Parameters:
N_NEURONS, 256, spike vector width; must be divisible by NUM_CLASSES.
NUM_CLASSES, 8, number of output classes; must be >= 2.
TIMESTEPS, 16, spike vectors per frame; must be >= 1.
GROUP (localparam), N_NEURONS/NUM_CLASSES, neurons per class.
CNT_W (localparam), $clog2(GROUP*TIMESTEPS+1), accumulator/score width (10 at defaults).
IDX_W (localparam), $clog2(NUM_CLASSES), class index width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_in  in  1  spike vector valid
ready_in  out  1  block can accept a spike vector
spikes_in  in  N_NEURONS  spike vector; class c owns bits [c*GROUP +: GROUP]
valid_out  out  1  classification result valid
ready_out  in  1  downstream accepts result
class_out  out  IDX_W  winning class index
score_out  out  CNT_W  accumulated spike count of the winning class

Behaviour:
- Reset clears all state asynchronously:
  - state=ACCUM, step counter=0, all accumulators=0, best_idx=0, best_score=0, scan index=0.
  - Outputs: valid_out=0, class_out=0, score_out=0, ready_in=1.
- FSM states ACCUM, SCAN, OUT. ready_in=1 only in ACCUM (decoded from state). valid_out=1 only in OUT.
- ACCUM:
  - On each edge with valid_in&&ready_in, acc[c] += popcount(spikes_in[c*GROUP +: GROUP]) for all c in parallel, and step increments.
  - Cycles without valid_in leave all state unchanged. Gaps between beats are legal.
  - When the beat accepted has step==TIMESTEPS-1: step<=0, state<=SCAN, scan index<=0, best_score<=0, best_idx<=0.
  - With TIMESTEPS=1, every accepted beat completes a frame.
- SCAN, one class per cycle:
  - If acc[idx] > best_score (strict), then best_score<=acc[idx] and best_idx<=idx.
  - idx increments each cycle. After idx==NUM_CLASSES-1 is processed, state<=OUT.
  - Strict compare means ties resolve to the lowest index; an all-zero frame yields class 0, score 0.
- Latency: if the last beat is accepted at edge E, SCAN occupies edges E+1..E+NUM_CLASSES, and valid_out is high in the cycle after edge E+NUM_CLASSES (8 cycles at defaults).
- OUT:
  - class_out=best_idx and score_out=best_score, held stable while valid_out=1 and ready_out=0 (registered, no glitch).
  - On valid_out&&ready_out: all accumulators cleared to 0, state<=ACCUM, valid_out deasserts the next cycle. ready_in is high in that next cycle, not in the same cycle.
  - class_out/score_out keep their last value after the handshake until the next result is produced.
- valid_in during SCAN/OUT is ignored: ready_in=0, no accumulation, no data loss accounting.
- Width: CNT_W sized for the maximum count GROUP*TIMESTEPS, so overflow is impossible. No saturation logic.
- Reset mid-frame or mid-scan discards the partial frame. The next frame starts from zero accumulators and step 0.
- Parameter violations (N_NEURONS%NUM_CLASSES!=0, NUM_CLASSES<2, TIMESTEPS<1) are caught by an elaboration-time $error.

Test Plan:
- Reset check: assert rst with clk running, then release -> valid_out=0, ready_in=1, class_out=0, score_out=0.
- Single dominant class (defaults): 16 beats with bits [96+:32] all ones and all other bits 0, ready_out=1 -> class_out=3, score_out=512. valid_out rises exactly 8 cycles after the 16th accept edge and is high for 1 cycle.
- Tie break: 16 beats each with 4 ones in group 2 and 4 ones in group 5, plus 1 one in group 0 -> class_out=2, score_out=64.
- All-zero frame with random valid_in gaps (16 accepted beats over about 40 cycles) -> class_out=0, score_out=0. Gaps do not alter the result.
- Backpressure: run the frame from the dominant-class test with ready_out=0 for 20 cycles after valid_out rises, and pulse valid_in throughout -> valid_out stays 1, class_out/score_out stay stable, ready_in=0, nothing is accumulated. After the handshake, a second frame with group 7 all ones -> class_out=7, score_out=512 (no carry-over).
- Reset mid-frame: accept 7 beats with group 1 all ones, assert rst, then send 16 beats with group 4 having 2 ones each -> class_out=4, score_out=32.
